// File: rtl/mem_resp_pkg.sv
// Shared defaults and FSM state type for the memory responder.
// DEPTH is always derived from AW so that every address maps to exactly one word.
package mem_resp_pkg;

  localparam int unsigned AW_DEF    = 11;
  localparam int unsigned DW_DEF    = 16;
  localparam int unsigned DEPTH_DEF = 2 ** AW_DEF;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_e;

endpackage

// File: rtl/mem_responder_if.sv
// Initiator <-> responder bus: request strobes in, read data and session status out.
interface mem_responder_if
  import mem_resp_pkg::*;
#(
  parameter int unsigned AW = AW_DEF,
  parameter int unsigned DW = DW_DEF
);

  logic          chip_sel;
  logic          wr_en;
  logic          rd_en;
  logic [AW-1:0] address;
  logic [DW-1:0] data_in;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic          rd_uninit;
  logic          protocol_err;
  logic [AW:0]   wr_count;
  logic [AW:0]   rd_count;
  logic          session_done;

  modport master (
    output chip_sel, wr_en, rd_en, address, data_in,
    input  rd_data, rd_valid, rd_uninit, protocol_err,
    input  wr_count, rd_count, session_done
  );

  modport slave (
    input  chip_sel, wr_en, rd_en, address, data_in,
    output rd_data, rd_valid, rd_uninit, protocol_err,
    output wr_count, rd_count, session_done
  );

endinterface

// File: rtl/mem_resp_array.sv
// DEPTH x DW single-port-style storage: synchronous write, registered read.
// Only the output register is reset; the word array itself is left uninitialised.
module mem_resp_array
  import mem_resp_pkg::*;
#(
  parameter int unsigned AW    = AW_DEF,
  parameter int unsigned DW    = DW_DEF,
  parameter int unsigned DEPTH = DEPTH_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Output register holds its value between reads so rd_data stays stable.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_responder.sv
// Session-based memory responder: IDLE/ACTIVE session FSM, written-word bitmap,
// saturating access counters and protocol checking around a registered-read array.
module mem_responder
  import mem_resp_pkg::*;
#(
  parameter int unsigned AW    = AW_DEF,
  parameter int unsigned DW    = DW_DEF,
  parameter int unsigned DEPTH = DEPTH_DEF
) (
  input  logic           clk,
  input  logic           reset,
  mem_responder_if.slave bus
);

  localparam logic [AW:0] CNT_MAX = '1;
  localparam logic [AW:0] CNT_ONE = (AW + 1)'(1);

  state_e           state_q, state_d;
  logic [DEPTH-1:0] bitmap_q, bitmap_d;
  logic [AW:0]      wr_count_q, wr_count_d;
  logic [AW:0]      rd_count_q, rd_count_d;
  logic             rd_valid_q, rd_valid_d;
  logic             rd_uninit_q, rd_uninit_d;
  logic             perr_q, perr_d;
  logic             done_q, done_d;

  logic active;
  logic start;
  logic wr_do;
  logic rd_do;

  assign active = (state_q == ACTIVE);
  assign start  = !active && bus.chip_sel;
  // A simultaneous read/write still performs the write; only the read is dropped.
  assign wr_do  = active && bus.chip_sel && bus.wr_en;
  assign rd_do  = active && bus.chip_sel && bus.rd_en && !bus.wr_en;

  always_comb begin
    state_d     = state_q;
    done_d      = 1'b0;
    bitmap_d    = bitmap_q;
    wr_count_d  = wr_count_q;
    rd_count_d  = rd_count_q;
    rd_valid_d  = rd_do;
    rd_uninit_d = rd_do && !bitmap_q[bus.address];
    perr_d      = (bus.wr_en && bus.rd_en) ||
                  ((bus.wr_en || bus.rd_en) && !(active && bus.chip_sel));

    case (state_q)
      IDLE: begin
        if (bus.chip_sel) begin
          state_d = ACTIVE;
        end
      end
      ACTIVE: begin
        if (!bus.chip_sel) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Session start and accesses are mutually exclusive, so clearing wins trivially.
    if (start) begin
      bitmap_d   = '0;
      wr_count_d = '0;
      rd_count_d = '0;
    end else begin
      if (wr_do) begin
        bitmap_d[bus.address] = 1'b1;
        if (wr_count_q != CNT_MAX) begin
          wr_count_d = wr_count_q + CNT_ONE;
        end
      end
      if (rd_do && (rd_count_q != CNT_MAX)) begin
        rd_count_d = rd_count_q + CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      bitmap_q    <= '0;
      wr_count_q  <= '0;
      rd_count_q  <= '0;
      rd_valid_q  <= 1'b0;
      rd_uninit_q <= 1'b0;
      perr_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      bitmap_q    <= bitmap_d;
      wr_count_q  <= wr_count_d;
      rd_count_q  <= rd_count_d;
      rd_valid_q  <= rd_valid_d;
      rd_uninit_q <= rd_uninit_d;
      perr_q      <= perr_d;
      done_q      <= done_d;
    end
  end

  mem_resp_array #(
    .AW    (AW),
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_array (
    .clk     (clk),
    .reset   (reset),
    .we_i    (wr_do),
    .waddr_i (bus.address),
    .wdata_i (bus.data_in),
    .re_i    (rd_do),
    .raddr_i (bus.address),
    .rdata_o (bus.rd_data)
  );

  assign bus.rd_valid     = rd_valid_q;
  assign bus.rd_uninit    = rd_uninit_q;
  assign bus.protocol_err = perr_q;
  assign bus.wr_count     = wr_count_q;
  assign bus.rd_count     = rd_count_q;
  assign bus.session_done = done_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: a vector table for single-cycle behaviour plus
// hand sequences for the full sweep, counter saturation and reset abort.
module tb_mem_responder;
  import mem_resp_pkg::*;

  logic clk;
  logic reset;
  int   n_tests;
  int   n_fail;

  mem_responder_if #(.AW(11), .DW(16)) bus ();

  mem_responder #(.AW(11), .DW(16), .DEPTH(2048)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        cs;
    logic        wr;
    logic        rd;
    logic [10:0] addr;
    logic [15:0] din;
    logic        valid;
    logic        chk_data;
    logic [15:0] data;
    logic        uninit;
    logic        err;
    logic        done;
    logic [11:0] wrc;
    logic [11:0] rdc;
  } vec_t;

  vec_t vecs [15];

  function automatic vec_t mk(logic cs, logic wr, logic rd, logic [10:0] a, logic [15:0] d,
                              logic v, logic cd, logic [15:0] ed, logic u, logic e,
                              logic dn, logic [11:0] wc, logic [11:0] rc);
    vec_t t;
    t.cs = cs; t.wr = wr; t.rd = rd; t.addr = a; t.din = d;
    t.valid = v; t.chk_data = cd; t.data = ed; t.uninit = u; t.err = e;
    t.done = dn; t.wrc = wc; t.rdc = rc;
    return t;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(logic cs, logic wr, logic rd, logic [10:0] a, logic [15:0] d);
    @(negedge clk);
    bus.chip_sel = cs;
    bus.wr_en    = wr;
    bus.rd_en    = rd;
    bus.address  = a;
    bus.data_in  = d;
  endtask

  task automatic check_all_zero(string tag);
    check({tag, ".rd_valid"},     32'(bus.rd_valid),     32'd0);
    check({tag, ".rd_data"},      32'(bus.rd_data),      32'd0);
    check({tag, ".rd_uninit"},    32'(bus.rd_uninit),    32'd0);
    check({tag, ".protocol_err"}, 32'(bus.protocol_err), 32'd0);
    check({tag, ".wr_count"},     32'(bus.wr_count),     32'd0);
    check({tag, ".rd_count"},     32'(bus.rd_count),     32'd0);
    check({tag, ".session_done"}, 32'(bus.session_done), 32'd0);
  endtask

  initial begin
    int n_done;
    n_tests = 0;
    n_fail  = 0;

    //               cs wr rd addr    din       vld cd data      un er dn wrc rdc
    vecs[0]  = mk(1, 0, 0, 11'h000, 16'h0000, 0, 0, 16'h0000, 0, 0, 0, 0, 0);
    vecs[1]  = mk(1, 1, 0, 11'h000, 16'hA5A5, 0, 1, 16'h0000, 0, 0, 0, 1, 0);
    vecs[2]  = mk(1, 0, 1, 11'h000, 16'h0000, 1, 1, 16'hA5A5, 0, 0, 0, 1, 1);
    vecs[3]  = mk(1, 0, 0, 11'h000, 16'h0000, 0, 1, 16'hA5A5, 0, 0, 0, 1, 1);
    vecs[4]  = mk(1, 1, 1, 11'h010, 16'h1234, 0, 1, 16'hA5A5, 0, 1, 0, 2, 1);
    vecs[5]  = mk(1, 0, 1, 11'h010, 16'h0000, 1, 1, 16'h1234, 0, 0, 0, 2, 2);
    vecs[6]  = mk(1, 0, 1, 11'h123, 16'h0000, 1, 0, 16'h0000, 1, 0, 0, 2, 3);
    vecs[7]  = mk(0, 1, 0, 11'h050, 16'hDEAD, 0, 0, 16'h0000, 0, 1, 1, 2, 3);
    vecs[8]  = mk(0, 0, 0, 11'h000, 16'h0000, 0, 0, 16'h0000, 0, 0, 0, 2, 3);
    vecs[9]  = mk(1, 1, 0, 11'h050, 16'hDEAD, 0, 0, 16'h0000, 0, 1, 0, 0, 0);
    vecs[10] = mk(1, 0, 1, 11'h050, 16'h0000, 1, 0, 16'h0000, 1, 0, 0, 0, 1);
    vecs[11] = mk(1, 0, 1, 11'h000, 16'h0000, 1, 1, 16'hA5A5, 1, 0, 0, 0, 2);
    vecs[12] = mk(1, 1, 0, 11'h123, 16'hBEEF, 0, 1, 16'hA5A5, 0, 0, 0, 1, 2);
    vecs[13] = mk(1, 0, 1, 11'h123, 16'h0000, 1, 1, 16'hBEEF, 0, 0, 0, 1, 3);
    vecs[14] = mk(0, 0, 0, 11'h000, 16'h0000, 0, 1, 16'hBEEF, 0, 0, 1, 1, 3);

    bus.chip_sel = 1'b0;
    bus.wr_en    = 1'b0;
    bus.rd_en    = 1'b0;
    bus.address  = '0;
    bus.data_in  = '0;
    reset        = 1'b1;
    #1;
    check_all_zero("reset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Table: each vector's registered response is visible just after the next edge.
    for (int i = 0; i < 15; i++) begin
      drive(vecs[i].cs, vecs[i].wr, vecs[i].rd, vecs[i].addr, vecs[i].din);
      @(posedge clk);
      #1;
      check("vec.rd_valid",     32'(bus.rd_valid),     32'(vecs[i].valid));
      if (vecs[i].chk_data) check("vec.rd_data", 32'(bus.rd_data), 32'(vecs[i].data));
      check("vec.rd_uninit",    32'(bus.rd_uninit),    32'(vecs[i].uninit));
      check("vec.protocol_err", 32'(bus.protocol_err), 32'(vecs[i].err));
      check("vec.session_done", 32'(bus.session_done), 32'(vecs[i].done));
      check("vec.wr_count",     32'(bus.wr_count),     32'(vecs[i].wrc));
      check("vec.rd_count",     32'(bus.rd_count),     32'(vecs[i].rdc));
      $display("[TB] vec %0d cs=%0b wr=%0b rd=%0b addr=%03h -> vld=%0b data=%04h un=%0b err=%0b done=%0b wc=%0d rc=%0d",
               i, vecs[i].cs, vecs[i].wr, vecs[i].rd, vecs[i].addr, bus.rd_valid, bus.rd_data,
               bus.rd_uninit, bus.protocol_err, bus.session_done, bus.wr_count, bus.rd_count);
    end

    // Full sweep: write every address, read every address back.
    drive(1, 0, 0, 11'h000, 16'h0000);
    for (int a = 0; a < 2048; a++) begin
      drive(1, 1, 0, 11'(a), 16'(a) ^ 16'h5555);
    end
    for (int a = 0; a < 2048; a++) begin
      drive(1, 0, 1, 11'(a), 16'h0000);
      @(posedge clk);
      #1;
      check("sweep.rd_valid",  32'(bus.rd_valid),  32'd1);
      check("sweep.rd_data",   32'(bus.rd_data),   32'(16'(a) ^ 16'h5555));
      check("sweep.rd_uninit", 32'(bus.rd_uninit), 32'd0);
    end
    check("sweep.wr_count", 32'(bus.wr_count), 32'd2048);
    check("sweep.rd_count", 32'(bus.rd_count), 32'd2048);
    drive(0, 0, 0, 11'h000, 16'h0000);
    n_done = 0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #1;
      if (bus.session_done) n_done++;
    end
    check("sweep.session_done_pulses", 32'(n_done), 32'd1);
    check("sweep.wr_count_hold", 32'(bus.wr_count), 32'd2048);
    $display("[TB] sweep done wc=%0d rc=%0d done_pulses=%0d", bus.wr_count, bus.rd_count, n_done);

    // Saturation: 4100 writes must stop at 4095.
    drive(1, 0, 0, 11'h000, 16'h0000);
    for (int a = 0; a < 4100; a++) begin
      drive(1, 1, 0, 11'(a), 16'(a));
    end
    @(posedge clk);
    #1;
    check("sat.wr_count", 32'(bus.wr_count), 32'd4095);
    check("sat.rd_count", 32'(bus.rd_count), 32'd0);
    $display("[TB] saturation wc=%0d", bus.wr_count);
    drive(0, 0, 0, 11'h000, 16'h0000);
    repeat (2) @(posedge clk);

    // Reset lands while a read is pending: no rd_valid and no session_done afterwards.
    drive(1, 0, 0, 11'h000, 16'h0000);
    drive(1, 1, 0, 11'h200, 16'h7777);
    drive(1, 0, 1, 11'h200, 16'h0000);
    #2;
    reset        = 1'b1;
    bus.chip_sel = 1'b0;
    bus.rd_en    = 1'b0;
    #1;
    check_all_zero("rst_abort.during");
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #1;
      check_all_zero("rst_abort.after");
    end
    $display("[TB] reset abort vld=%0b done=%0b", bus.rd_valid, bus.session_done);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter AW, default 11, address width.
REQ-002 Parameter DW, default 16, data width.
REQ-003 Parameter DEPTH, default 2048, storage words, equal to 2**AW.
REQ-004 Port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-005 Port reset, input, 1, asynchronous active-high reset.
REQ-006 Port chip_sel, input, 1, session enable from the initiator.
REQ-007 Port wr_en, input, 1, write strobe, one cycle per access.
REQ-008 Port rd_en, input, 1, read strobe, one cycle per access.
REQ-009 Port address, input, AW, word address.
REQ-010 Port data_in, input, DW, write data.
REQ-011 Port rd_data, output, DW, registered read data.
REQ-012 Port rd_valid, output, 1, one-cycle pulse qualifying rd_data.
REQ-013 Port rd_uninit, output, 1, pulse with rd_valid when the read word was never written this session.
REQ-014 Port protocol_err, output, 1, one-cycle pulse on an illegal strobe combination.
REQ-015 Port wr_count, output, AW+1, writes accepted this session, saturating.
REQ-016 Port rd_count, output, AW+1, reads accepted this session, saturating.
REQ-017 Port session_done, output, 1, one-cycle pulse when a session ends.

Function
REQ-018 FSM shall have states IDLE and ACTIVE; IDLE->ACTIVE when chip_sel=1; ACTIVE->IDLE when chip_sel=0, asserting session_done in the following cycle.
REQ-019 On IDLE->ACTIVE: wr_count, rd_count and the DEPTH-bit written-bitmap shall clear; counts shall hold their values after session end until the next session start.
REQ-020 Write accepted when ACTIVE, chip_sel=1, wr_en=1, rd_en=0: store data_in at address, set bitmap[address], and increment wr_count.
REQ-021 Read accepted when ACTIVE, chip_sel=1, rd_en=1, wr_en=0: rd_data=mem[address] with rd_valid=1 exactly one cycle later (latency 1), and increment rd_count.
REQ-022 rd_uninit shall equal ~bitmap[address] sampled at read acceptance, output aligned with rd_valid.
REQ-023 A read following a write to the same address in the next cycle shall return the newly written data.
REQ-024 wr_en=1 and rd_en=1 in the same cycle: write performed, read suppressed (no rd_valid), protocol_err pulsed.
REQ-025 wr_en or rd_en high while chip_sel=0 or state=IDLE: access ignored, protocol_err pulsed.
REQ-026 rd_data shall hold its last value when rd_valid=0.
REQ-027 Counters shall saturate at 2**(AW+1)-1 and never wrap; 2048 writes yields wr_count=2048.
REQ-028 Address wrap is the initiator's concern; every AW-bit address is legal, no bounds error.

Reset
REQ-029 On reset: state=IDLE; rd_data=0, rd_valid=0, rd_uninit=0, protocol_err=0, wr_count=0, rd_count=0, session_done=0; bitmap all 0.
REQ-030 Storage array contents are not reset and are undefined after reset.
REQ-031 Reset mid-session shall abort any pending read (no rd_valid after release) and shall not pulse session_done.

Structure
REQ-032 Package mem_resp_pkg shall hold AW, DW, DEPTH defaults and the state enum (IDLE, ACTIVE).
REQ-033 Sub-module mem_resp_array shall implement DEPTH x DW storage with synchronous write and registered read; the bitmap and counters stay in mem_responder.

Verification
REQ-034 Write 0xA5A5 to 0x000, read 0x000 -> rd_valid one cycle after rd_en, rd_data=0xA5A5, rd_uninit=0.
REQ-035 New session, read 0x123 without writing it -> rd_valid=1, rd_uninit=1, rd_count=1.
REQ-036 Full sweep: write then read addresses 0x000..0x7FF with data=address^0x5555 -> all reads match; wr_count=rd_count=2048; session_done pulses once after chip_sel falls.
REQ-037 wr_en=rd_en=1 at 0x010 with data 0x1234 -> protocol_err pulse, no rd_valid; later read of 0x010 returns 0x1234.
REQ-038 wr_en with chip_sel=0 -> protocol_err pulse, wr_count unchanged, bitmap unchanged.
REQ-039 Reset asserted the cycle after rd_en -> rd_valid stays 0, all outputs 0, no session_done.
